input_debounce_step: RTL and testbench

//  Conditions the two board inputs that drive the 6-state sequence FSM: the

---
 rtl/input_debounce_step_pkg.sv | 15 +
 rtl/input_debounce_step_if.sv | 18 +
 rtl/input_debounce_step_debounce_core.sv | 49 ++++
 rtl/input_debounce_step.sv | 104 ++++++++++
 tb/tb_input_debounce_step.sv | 121 ++++++++++++
 5 files changed

// File: rtl/input_debounce_step_pkg.sv
// Shared types and default timing constants for the step/direction input conditioner.
package input_debounce_step_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    REPEAT  = 2'd2
  } btn_state_e;

  localparam logic [31:0] TimeExpire              = 32'd25000000;
  localparam logic [31:0] DEFAULT_DEBOUNCE_CYCLES = 32'd1000000;
  localparam logic [31:0] DEFAULT_REPEAT_CYCLES   = TimeExpire;
  localparam int unsigned DEFAULT_CNT_W           = 32;

endpackage

// File: rtl/input_debounce_step_if.sv
// Board-pin side and FSM side signals of the input conditioner.
interface input_debounce_step_if;
  logic btn_raw;
  logic sw_raw;
  logic in_clean;
  logic step_pulse;
  logic btn_held;

  modport master (
    output btn_raw, sw_raw,
    input  in_clean, step_pulse, btn_held
  );

  modport slave (
    input  btn_raw, sw_raw,
    output in_clean, step_pulse, btn_held
  );
endinterface

// File: rtl/input_debounce_step_debounce_core.sv
// Two-flop synchroniser plus stability counter; flags the cycle on which the
// caller-held debounced level must flip.
module debounce_core
  import input_debounce_step_pkg::*;
#(
  parameter logic [31:0] DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic level,
  output logic toggle
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
    end
  end

  // The level register lives with the caller so the flip can be acted on in the same cycle.
  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    cnt_d   = '0;
    toggle  = 1'b0;
    if (sync2_q != level) begin
      if (cnt_q == CNT_LAST) begin
        toggle = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/input_debounce_step.sv
// Debounces the direction switch and step button, producing a clean level and a
// one-clk step pulse per press with auto-repeat while held.
module input_debounce_step
  import input_debounce_step_pkg::*;
#(
  parameter logic [31:0] DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic [31:0] REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES,
  parameter int unsigned CNT_W           = DEFAULT_CNT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input_debounce_step_if.slave  io
);

  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 32'd1);

  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] rpt_q, rpt_d;
  logic             step_pulse_q, step_pulse_d;
  logic             btn_held_q, btn_held_d;
  logic             in_clean_q, in_clean_d;
  logic             btn_toggle, sw_toggle;
  logic             btn_rise, btn_fall;

  debounce_core #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_btn_db (
    .clk    (clk),
    .rst_n  (reset),
    .raw    (io.btn_raw),
    .level  (btn_held_q),
    .toggle (btn_toggle)
  );

  debounce_core #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_sw_db (
    .clk    (clk),
    .rst_n  (reset),
    .raw    (io.sw_raw),
    .level  (in_clean_q),
    .toggle (sw_toggle)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      rpt_q        <= '0;
      step_pulse_q <= 1'b0;
      btn_held_q   <= 1'b0;
      in_clean_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rpt_q        <= rpt_d;
      step_pulse_q <= step_pulse_d;
      btn_held_q   <= btn_held_d;
      in_clean_q   <= in_clean_d;
    end
  end

  assign btn_rise = btn_toggle & ~btn_held_q;
  assign btn_fall = btn_toggle &  btn_held_q;

  always_comb begin
    state_d      = state_q;
    rpt_d        = rpt_q;
    step_pulse_d = 1'b0;
    btn_held_d   = btn_held_q ^ btn_toggle;
    in_clean_d   = in_clean_q ^ sw_toggle;
    unique case (state_q)
      IDLE: begin
        rpt_d = '0;
        if (btn_rise) begin
          state_d      = PRESSED;
          step_pulse_d = 1'b1;
        end
      end
      PRESSED, REPEAT: begin
        // Release is checked first so an expiry on the release edge emits nothing.
        if (btn_fall) begin
          state_d = IDLE;
          rpt_d   = '0;
        end else if (rpt_q == RPT_LAST) begin
          state_d      = REPEAT;
          rpt_d        = '0;
          step_pulse_d = 1'b1;
        end else begin
          rpt_d = rpt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        rpt_d   = '0;
      end
    endcase
  end

  assign io.step_pulse = step_pulse_q;
  assign io.btn_held   = btn_held_q;
  assign io.in_clean   = in_clean_q;

endmodule

// File: tb/tb_input_debounce_step.sv
// Directed bench for input_debounce_step with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8.
module tb_input_debounce_step;

  logic        clk = 1'b0;
  logic        rst_n;
  int unsigned total = 0;
  int unsigned bad   = 0;

  input_debounce_step_if bus ();

  input_debounce_step #(
    .DEBOUNCE_CYCLES (32'd4),
    .REPEAT_CYCLES   (32'd8),
    .CNT_W           (32)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .io    (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic ep, input logic eh, input logic ei);
    chk({tag, ".step_pulse"}, bus.step_pulse, ep);
    chk({tag, ".btn_held"},   bus.btn_held,   eh);
    chk({tag, ".in_clean"},   bus.in_clean,   ei);
  endtask

  initial begin
    // Reset held with both pins high
    rst_n       = 1'b0;
    bus.btn_raw = 1'b1;
    bus.sw_raw  = 1'b1;
    tick; tick; tick;
    chk3("rst_hold", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick;
      chk3("rst_release", i == 6, i >= 6, i >= 6);
    end

    // Release lands on the same edge as the first repeat expiry
    bus.btn_raw = 1'b0;
    bus.sw_raw  = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick;
      chk3("release_vs_expiry", 1'b0, i < 6, i < 6);
    end

    // Clean 5-cycle press
    bus.btn_raw = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      tick;
      chk3("clean_press", i == 6, (i >= 6) && (i < 11), 1'b0);
      if (i == 5) bus.btn_raw = 1'b0;
    end

    // Bounce every 2 cycles for 20 cycles
    for (int i = 1; i <= 24; i++) begin
      bus.btn_raw = (i <= 20) && ((((i - 1) / 2) % 2) == 0);
      tick;
      chk3("bounce", 1'b0, 1'b0, 1'b0);
    end

    // Hold 40 cycles: auto-repeat
    bus.btn_raw = 1'b1;
    for (int i = 1; i <= 52; i++) begin
      tick;
      chk3("auto_repeat", (i == 6) || (i == 14) || (i == 22) || (i == 30) || (i == 38),
           (i >= 6) && (i < 46), 1'b0);
      if (i == 40) bus.btn_raw = 1'b0;
    end

    // Switch glitch of 3 cycles, then stable high
    bus.sw_raw = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick;
      chk3("sw_glitch", 1'b0, 1'b0, 1'b0);
      if (i == 3) bus.sw_raw = 1'b0;
    end
    bus.sw_raw = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick;
      chk3("sw_stable", 1'b0, 1'b0, i >= 6);
    end

    // Reset during REPEAT with button and switch still held
    bus.btn_raw = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick;
      chk3("pre_reset", (i == 6) || (i == 14), i >= 6, 1'b1);
    end
    rst_n = 1'b0;
    #1;
    chk3("mid_reset_async", 1'b0, 1'b0, 1'b0);
    tick; tick;
    chk3("mid_reset_hold", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick;
      chk3("requalify", i == 6, i >= 6, i >= 6);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
